// File: rtl/combine_pcre_eop_pkg.sv
// Shared types and widths for the content/PCRE rule-combination stage.
package combine_pcre_eop_pkg;

    localparam int unsigned RULE_ID_W = 10;
    localparam int unsigned FLOW_W    = 7;
    localparam int unsigned NUM_LANES = 3;
    localparam int unsigned NUM_EV    = NUM_LANES + 1;

    localparam logic [RULE_ID_W-1:0] NO_EVENT = '0;

    // Rule word on the lanes and on the output: {ctrl/valid, id}
    typedef struct packed {
        logic                 ctrl;
        logic [RULE_ID_W-1:0] id;
    } rule_word_t;

    typedef struct packed {
        logic [RULE_ID_W-1:0] id;
        logic [FLOW_W-1:0]    flow;
    } q_entry_t;

endpackage

// File: rtl/combine_pcre_eop_delay_line.sv
// Fixed-length 1-bit shift register used for the end_of_packet taps (DEPTH >= 2).
module eop_delay_line #(
    parameter int unsigned DEPTH = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    assign sr_d = {sr_q[DEPTH-2:0], d_i};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/combine_pcre_eop.sv
// Merges content-match lanes with PCRE matches per packet and streams each
// completed rule once through a multi-push queue; also hosts the EOP delay taps.
module combine_pcre_eop
    import combine_pcre_eop_pkg::*;
#(
    parameter int unsigned NUM_RULES  = 1024,
    parameter int unsigned FIFO_DEPTH = 32,
    parameter int unsigned DLY_A      = 7,
    parameter int unsigned DLY_B      = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 state,
    input  logic [FLOW_W-1:0]    flow,
    input  logic                 end_of_packet,
    input  logic                 end_of_packet_shift,
    input  logic [RULE_ID_W:0]   patternID_out1,
    input  logic [RULE_ID_W:0]   patternID_out3,
    input  logic [RULE_ID_W:0]   patternID_out5,
    input  logic [RULE_ID_W-1:0] patternID_pcre,
    output logic [RULE_ID_W:0]   real_patternID,
    output logic [FLOW_W-1:0]    rule_flow,
    output logic                 combine_ready,
    output logic                 overflow,
    output logic                 eop_d7,
    output logic                 eop_d12
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [NUM_EV-1:0] EV_IS_CNT = {1'b0, {NUM_LANES{1'b1}}};

    // Per-rule records, cleared in bulk at end of packet
    logic [NUM_RULES-1:0] ch_q, np_q, ph_q, em_q;

    logic [RULE_ID_W:0]   real_q;
    logic [FLOW_W-1:0]    flow_q;
    logic                 ready_q;
    logic                 ovf_q;

    q_entry_t             fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic [PTR_W-1:0]     rd_ptr_d, wr_ptr_d;
    logic [CNT_W-1:0]     count_d;

    rule_word_t           lane_w [NUM_LANES];
    logic                 accept_c;
    logic [NUM_EV-1:0]    ev_vld_c;
    logic [NUM_EV-1:0]    ev_need_c;
    logic [RULE_ID_W-1:0] ev_id_c [NUM_EV];

    logic [NUM_EV-1:0]    ch_new_c, np_new_c, ph_new_c, em_new_c;
    logic [NUM_EV-1:0]    fire_c;

    logic                 pop_c;
    logic [CNT_W-1:0]     free_c;
    logic [CNT_W-1:0]     push_cnt_c;
    logic [CNT_W-1:0]     slot_ofs_c [NUM_EV];
    logic [NUM_EV-1:0]    push_ok_c;
    logic                 drop_c;

    assign lane_w[0] = rule_word_t'(patternID_out1);
    assign lane_w[1] = rule_word_t'(patternID_out3);
    assign lane_w[2] = rule_word_t'(patternID_out5);

    assign accept_c = state && !end_of_packet_shift;

    // Event extraction: three content lanes followed by the PCRE input
    always_comb begin
        ev_vld_c  = '0;
        ev_need_c = '0;
        for (int i = 0; i < NUM_EV; i++) begin
            ev_id_c[i] = NO_EVENT;
        end
        for (int i = 0; i < NUM_LANES; i++) begin
            ev_id_c[i]   = lane_w[i].id;
            ev_need_c[i] = lane_w[i].ctrl;
            ev_vld_c[i]  = accept_c && (lane_w[i].id != NO_EVENT);
        end
        ev_id_c[NUM_EV-1]  = patternID_pcre;
        ev_vld_c[NUM_EV-1] = accept_c && (patternID_pcre != NO_EVENT);
    end

    // Record update including every same-cycle event on the same ID;
    // only the first event carrying a given ID may push it.
    always_comb begin
        logic ch;
        logic np;
        logic ph;
        logic em;
        logic ok;
        logic dup;
        ch       = 1'b0;
        np       = 1'b0;
        ph       = 1'b0;
        em       = 1'b0;
        ok       = 1'b0;
        dup      = 1'b0;
        ch_new_c = '0;
        np_new_c = '0;
        ph_new_c = '0;
        em_new_c = '0;
        fire_c   = '0;
        for (int i = 0; i < NUM_EV; i++) begin
            ch  = ch_q[ev_id_c[i]];
            np  = np_q[ev_id_c[i]];
            ph  = ph_q[ev_id_c[i]];
            em  = em_q[ev_id_c[i]];
            dup = 1'b0;
            for (int j = 0; j < NUM_EV; j++) begin
                if (ev_vld_c[j] && (ev_id_c[j] == ev_id_c[i])) begin
                    if (EV_IS_CNT[j]) begin
                        ch = 1'b1;
                        np = ev_need_c[j];
                    end else begin
                        ph = 1'b1;
                    end
                    if (j < i) begin
                        dup = 1'b1;
                    end
                end
            end
            ok          = ch && (!np || ph) && !em;
            ch_new_c[i] = ch;
            np_new_c[i] = np;
            ph_new_c[i] = ph;
            em_new_c[i] = em || ok;
            fire_c[i]   = ev_vld_c[i] && ok && !dup;
        end
    end

    // Slot allocation: fired rules packed in lane order into the free space
    always_comb begin
        logic [CNT_W-1:0] ofs;
        ofs       = '0;
        pop_c     = (count_q != '0);
        free_c    = CNT_W'(FIFO_DEPTH) - count_q + CNT_W'(pop_c);
        push_ok_c = '0;
        drop_c    = 1'b0;
        for (int i = 0; i < NUM_EV; i++) begin
            slot_ofs_c[i] = ofs;
            if (fire_c[i]) begin
                if (ofs < free_c) begin
                    push_ok_c[i] = 1'b1;
                    ofs          = ofs + CNT_W'(1);
                end else begin
                    drop_c = 1'b1;
                end
            end
        end
        push_cnt_c = ofs;
        count_d    = count_q - CNT_W'(pop_c) + push_cnt_c;
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop_c);
        wr_ptr_d   = wr_ptr_q + PTR_W'(push_cnt_c);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_q <= '0;
            np_q <= '0;
            ph_q <= '0;
            em_q <= '0;
        end else if (end_of_packet_shift) begin
            ch_q <= '0;
            np_q <= '0;
            ph_q <= '0;
            em_q <= '0;
        end else begin
            for (int i = 0; i < NUM_EV; i++) begin
                if (ev_vld_c[i]) begin
                    ch_q[ev_id_c[i]] <= ch_new_c[i];
                    np_q[ev_id_c[i]] <= np_new_c[i];
                    ph_q[ev_id_c[i]] <= ph_new_c[i];
                    em_q[ev_id_c[i]] <= em_new_c[i];
                end
            end
        end
    end

    // Queue storage needs no reset; validity is tracked by the pointers
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_EV; i++) begin
            if (push_ok_c[i]) begin
                fifo_q[wr_ptr_q + PTR_W'(slot_ofs_c[i])] <= q_entry_t'{id: ev_id_c[i], flow: flow};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            real_q   <= '0;
            flow_q   <= '0;
            ready_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (pop_c) begin
                real_q <= {1'b1, fifo_q[rd_ptr_q].id};
                flow_q <= fifo_q[rd_ptr_q].flow;
            end else begin
                real_q <= '0;
                flow_q <= '0;
            end
            ready_q <= (count_d == '0) && (push_cnt_c == '0);
            ovf_q   <= ovf_q || drop_c;
        end
    end

    eop_delay_line #(.DEPTH(DLY_A)) u_dly_a (
        .clk   (clk),
        .rst_n (rst),
        .d_i   (end_of_packet),
        .q_o   (eop_d7)
    );

    eop_delay_line #(.DEPTH(DLY_B)) u_dly_b (
        .clk   (clk),
        .rst_n (rst),
        .d_i   (end_of_packet),
        .q_o   (eop_d12)
    );

    assign real_patternID = real_q;
    assign rule_flow      = flow_q;
    assign combine_ready  = ready_q;
    assign overflow       = ovf_q;

endmodule

// File: tb/tb_combine_pcre_eop.sv
// Directed bench for combine_pcre_eop: vector table, overflow model, EOP taps, reset.
module tb_combine_pcre_eop;

    logic        clk = 1'b0;
    logic        rst;
    logic        state;
    logic [6:0]  flow;
    logic        end_of_packet;
    logic        end_of_packet_shift;
    logic [10:0] patternID_out1, patternID_out3, patternID_out5;
    logic [9:0]  patternID_pcre;
    logic [10:0] real_patternID;
    logic [6:0]  rule_flow;
    logic        combine_ready;
    logic        overflow;
    logic        eop_d7, eop_d12;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    combine_pcre_eop dut (
        .clk                 (clk),
        .rst                 (rst),
        .state               (state),
        .flow                (flow),
        .end_of_packet       (end_of_packet),
        .end_of_packet_shift (end_of_packet_shift),
        .patternID_out1      (patternID_out1),
        .patternID_out3      (patternID_out3),
        .patternID_out5      (patternID_out5),
        .patternID_pcre      (patternID_pcre),
        .real_patternID      (real_patternID),
        .rule_flow           (rule_flow),
        .combine_ready       (combine_ready),
        .overflow            (overflow),
        .eop_d7              (eop_d7),
        .eop_d12             (eop_d12)
    );

    typedef struct {
        logic        st;
        logic        sh;
        logic [10:0] l1;
        logic [10:0] l3;
        logic [10:0] l5;
        logic [9:0]  pc;
        logic [6:0]  fl;
        logic [10:0] e_real;
        logic [6:0]  e_flow;
        logic        e_rdy;
    } vec_t;

    typedef struct {
        logic [9:0] id;
        logic [6:0] fl;
    } ment_t;

    vec_t  vt[$];
    ment_t mq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic sh, input logic [10:0] l1, input logic [10:0] l3,
                         input logic [10:0] l5, input logic [9:0] pc, input logic [6:0] fl);
        state               = st;
        end_of_packet_shift = sh;
        patternID_out1      = l1;
        patternID_out3      = l3;
        patternID_out5      = l5;
        patternID_pcre      = pc;
        flow                = fl;
    endtask

    task automatic add(input logic st, input logic sh, input logic [10:0] l1, input logic [10:0] l3,
                       input logic [10:0] l5, input logic [9:0] pc, input logic [6:0] fl,
                       input logic [10:0] er, input logic [6:0] ef, input logic rdy);
        vec_t v;
        v.st = st; v.sh = sh; v.l1 = l1; v.l3 = l3; v.l5 = l5; v.pc = pc; v.fl = fl;
        v.e_real = er; v.e_flow = ef; v.e_rdy = rdy;
        vt.push_back(v);
    endtask

    initial begin
        logic [10:0] ids [3];
        logic        ovf_m;
        logic        pushed;
        int          free;
        int          guard;
        logic [10:0] exp_out;
        logic [6:0]  exp_fl;

        rst = 1'b0;
        end_of_packet = 1'b0;
        drive(1'b0, 1'b0, '0, '0, '0, '0, '0);
        repeat (2) tick();
        rst = 1'b1;
        tick();

        chk("reset_real", 32'(real_patternID), 32'h0);
        chk("reset_ready", 32'(combine_ready), 32'h1);
        chk("reset_ovf", 32'(overflow), 32'h0);
        chk("reset_d7", 32'(eop_d7), 32'h0);
        chk("reset_d12", 32'(eop_d12), 32'h0);

        // content-only rule, then repeat in same packet
        add(1, 0, 11'h005, 0, 0, 0, 7'd3, 11'h000, 7'd0, 0);
        add(1, 0, 0, 0, 0, 0, 7'd3, 11'h405, 7'd3, 1);
        add(1, 0, 0, 0, 0, 0, 7'd3, 11'h000, 7'd0, 1);
        add(1, 0, 11'h005, 0, 0, 0, 7'd3, 11'h000, 7'd0, 1);
        add(1, 0, 0, 0, 0, 0, 7'd3, 11'h000, 7'd0, 1);
        // PCRE-gated, content first
        add(1, 0, 0, 11'h40A, 0, 0, 7'd4, 11'h000, 7'd0, 1);
        add(1, 0, 0, 0, 0, 0, 7'd4, 11'h000, 7'd0, 1);
        add(1, 0, 0, 0, 0, 0, 7'd4, 11'h000, 7'd0, 1);
        add(1, 0, 0, 0, 0, 10'h00A, 7'd5, 11'h000, 7'd0, 0);
        add(1, 0, 0, 0, 0, 0, 7'd5, 11'h40A, 7'd5, 1);
        add(1, 0, 0, 0, 0, 0, 7'd5, 11'h000, 7'd0, 1);
        add(1, 1, 0, 0, 0, 0, 7'd5, 11'h000, 7'd0, 1);
        // PCRE first
        add(1, 0, 0, 0, 0, 10'h00B, 7'd6, 11'h000, 7'd0, 1);
        add(1, 0, 0, 0, 0, 0, 7'd6, 11'h000, 7'd0, 1);
        add(1, 0, 0, 0, 11'h40B, 0, 7'd7, 11'h000, 7'd0, 0);
        add(1, 0, 0, 0, 0, 0, 7'd7, 11'h40B, 7'd7, 1);
        add(1, 0, 0, 0, 0, 0, 7'd7, 11'h000, 7'd0, 1);
        // multi-event cycle with a duplicate
        add(1, 0, 11'h001, 11'h002, 11'h001, 0, 7'd8, 11'h000, 7'd0, 0);
        add(1, 0, 0, 0, 0, 0, 7'd8, 11'h401, 7'd8, 0);
        add(1, 0, 0, 0, 0, 0, 7'd8, 11'h402, 7'd8, 1);
        add(1, 0, 0, 0, 0, 0, 7'd8, 11'h000, 7'd0, 1);
        // packet boundary clears a pending content hit
        add(1, 1, 0, 0, 0, 0, 7'd9, 11'h000, 7'd0, 1);
        add(1, 0, 0, 0, 11'h40A, 0, 7'd9, 11'h000, 7'd0, 1);
        add(1, 1, 0, 0, 0, 0, 7'd9, 11'h000, 7'd0, 1);
        add(1, 0, 0, 0, 0, 10'h00A, 7'd9, 11'h000, 7'd0, 1);
        add(1, 0, 0, 0, 0, 0, 7'd9, 11'h000, 7'd0, 1);
        // end_of_packet_shift discards same-cycle events
        add(1, 1, 11'h007, 0, 0, 0, 7'd9, 11'h000, 7'd0, 1);
        add(1, 0, 0, 0, 0, 0, 7'd9, 11'h000, 7'd0, 1);
        add(1, 0, 11'h007, 0, 0, 0, 7'd10, 11'h000, 7'd0, 0);
        add(1, 0, 0, 0, 0, 0, 7'd10, 11'h407, 7'd10, 1);
        // idle state ignores events
        add(0, 0, 11'h009, 0, 0, 0, 7'd11, 11'h000, 7'd0, 1);
        add(1, 0, 0, 0, 0, 0, 7'd11, 11'h000, 7'd0, 1);
        add(1, 0, 11'h009, 0, 0, 0, 7'd11, 11'h000, 7'd0, 0);
        add(1, 0, 0, 0, 0, 0, 7'd11, 11'h409, 7'd11, 1);
        // content and PCRE for the same rule in one cycle
        add(1, 0, 11'h40D, 0, 0, 10'h00D, 7'd12, 11'h000, 7'd0, 0);
        add(1, 0, 0, 0, 0, 0, 7'd12, 11'h40D, 7'd12, 1);
        add(1, 0, 0, 0, 0, 0, 7'd12, 11'h000, 7'd0, 1);

        foreach (vt[k]) begin
            drive(vt[k].st, vt[k].sh, vt[k].l1, vt[k].l3, vt[k].l5, vt[k].pc, vt[k].fl);
            tick();
            chk($sformatf("vec%0d_real", k), 32'(real_patternID), 32'(vt[k].e_real));
            chk($sformatf("vec%0d_flow", k), 32'(rule_flow), 32'(vt[k].e_flow));
            chk($sformatf("vec%0d_ready", k), 32'(combine_ready), 32'(vt[k].e_rdy));
            chk($sformatf("vec%0d_ovf", k), 32'(overflow), 32'h0);
        end

        // delay taps: pulse in cycle 0
        drive(1'b0, 1'b0, '0, '0, '0, '0, '0);
        end_of_packet = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            end_of_packet = 1'b0;
            chk($sformatf("eop_d7_c%0d", k), 32'(eop_d7), 32'(k == 7));
            chk($sformatf("eop_d12_c%0d", k), 32'(eop_d12), 32'(k == 12));
        end

        // queue fill to overflow against a reference queue model
        drive(1'b1, 1'b1, '0, '0, '0, '0, '0);
        tick();
        ovf_m = 1'b0;
        for (int c = 0; c < 20; c++) begin
            ids[0] = 11'(100 + 3 * c);
            ids[1] = 11'(101 + 3 * c);
            ids[2] = 11'(102 + 3 * c);
            drive(1'b1, 1'b0, ids[0], ids[1], ids[2], '0, 7'(c));
            tick();
            exp_out = '0;
            exp_fl  = '0;
            if (mq.size() > 0) begin
                ment_t h;
                h = mq.pop_front();
                exp_out = {1'b1, h.id};
                exp_fl  = h.fl;
            end
            free   = 32 - mq.size();
            pushed = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (i < free) begin
                    ment_t e;
                    e.id = ids[i][9:0];
                    e.fl = 7'(c);
                    mq.push_back(e);
                    pushed = 1'b1;
                end else begin
                    ovf_m = 1'b1;
                end
            end
            chk($sformatf("fill%0d_real", c), 32'(real_patternID), 32'(exp_out));
            chk($sformatf("fill%0d_flow", c), 32'(rule_flow), 32'(exp_fl));
            chk($sformatf("fill%0d_ready", c), 32'(combine_ready), 32'((mq.size() == 0) && !pushed));
            chk($sformatf("fill%0d_ovf", c), 32'(overflow), 32'(ovf_m));
        end
        chk("ovf_reached", 32'(ovf_m), 32'h1);

        drive(1'b1, 1'b0, '0, '0, '0, '0, '0);
        guard = 0;
        while ((mq.size() > 0 || real_patternID != '0) && guard < 80) begin
            tick();
            guard++;
            exp_out = '0;
            exp_fl  = '0;
            if (mq.size() > 0) begin
                ment_t h;
                h = mq.pop_front();
                exp_out = {1'b1, h.id};
                exp_fl  = h.fl;
            end
            chk($sformatf("drain%0d_real", guard), 32'(real_patternID), 32'(exp_out));
            chk($sformatf("drain%0d_flow", guard), 32'(rule_flow), 32'(exp_fl));
            chk($sformatf("drain%0d_ready", guard), 32'(combine_ready), 32'(mq.size() == 0));
        end
        chk("drain_bound", 32'(guard < 80), 32'h1);
        chk("ovf_sticky", 32'(overflow), 32'h1);

        // reset mid-stream drops the entry in flight
        drive(1'b1, 1'b1, '0, '0, '0, '0, '0);
        tick();
        drive(1'b1, 1'b0, 11'h020, '0, '0, '0, 7'd1);
        tick();
        drive(1'b1, 1'b0, 11'h021, '0, '0, '0, 7'd2);
        tick();
        chk("pre_rst_real", 32'(real_patternID), 32'h420);
        chk("pre_rst_ready", 32'(combine_ready), 32'h0);
        drive(1'b0, 1'b0, '0, '0, '0, '0, '0);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_real", 32'(real_patternID), 32'h0);
        chk("rst_ready", 32'(combine_ready), 32'h1);
        chk("rst_ovf", 32'(overflow), 32'h0);
        rst = 1'b1;
        tick();
        tick();
        chk("post_rst_real", 32'(real_patternID), 32'h0);
        chk("post_rst_ready", 32'(combine_ready), 32'h1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
